mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares the single-ported OTTER main memory between two requesters:
  - instruction fetch (IF);
  - the memory stage load/store path (MA).
- Sequences each access as issue → latency wait → completion: one transaction in flight, one `*_VALID` pulse per transaction.
- Generates per-requester stall signals so the pipeline registers hold while their access is outstanding.
- Sits between the fetch/memory-stage logic and the `Memory` module.

## Interface

Parameters:
- `MEM_LATENCY`, default 2: cycles from the issue cycle until `MEM_RDATA` is valid; legal values ≥ 1.
- `MAX_DATA_STREAK`, default 4: consecutive MA grants allowed while IF is waiting before IF is forced; legal values ≥ 1.

Ports:
- `ARB_CLOCK`  in  1  sole clock, rising edge.
- `ARB_RESET`  in  1  synchronous, active-high reset.
- `IF_REQ`  in  1  fetch request, level.
- `IF_ADDR`  in  32  fetch address.
- `IF_RDATA`  out  32  fetched word.
- `IF_VALID`  out  1  one-cycle completion pulse for IF.
- `MA_REQ`  in  1  memory-stage request, level.
- `MA_WE`  in  1  1 = store, 0 = load.
- `MA_ADDR`  in  32  load/store address.
- `MA_WDATA`  in  32  store data.
- `MA_SIZE`  in  3  funct3 size/sign code.
- `MA_RDATA`  out  32  load data.
- `MA_VALID`  out  1  one-cycle completion pulse for MA.
- `MEM_ADDR`  out  32  memory address.
- `MEM_WDATA`  out  32  memory write data.
- `MEM_SIZE`  out  3  memory size code.
- `MEM_RDEN`  out  1  memory read enable.
- `MEM_WE`  out  1  memory write enable.
- `MEM_RDATA`  in  32  memory read data.
- `STALL_IF`  out  1  `IF_REQ & ~IF_VALID`, combinational.
- `STALL_MA`  out  1  `MA_REQ & ~MA_VALID`, combinational.

## Operation

FSM states: IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant MA, unless `streak == MAX_DATA_STREAK`, in which case grant IF.
  - On grant: register address, wdata, size and we (IF uses size 3'b010, we = 0) plus the owner; go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `MEM_RDEN = ~we`, `MEM_WE = we`.
  - Next state: WAIT with `cnt = MEM_LATENCY - 1`.
- **WAIT**
  - Enables low; `cnt` decrements each cycle.
  - At `cnt == 0`: capture `MEM_RDATA` (a store captures 0 instead) and go to DONE.
- **DONE** (1 cycle)
  - Owner's `*_VALID = 1`, and its `*_RDATA` shows the captured word.
  - Next state: IDLE.
- `MEM_ADDR`/`MEM_WDATA`/`MEM_SIZE` hold the captured values in every state outside IDLE and keep the last values while in IDLE.
- `IF_RDATA`/`MA_RDATA` hold their last captured values between transactions.
- Streak counter, width `$clog2(MAX_DATA_STREAK+1)`:
  - increments on an MA grant while `IF_REQ = 1`;
  - clears on any IF grant, and on an MA grant while `IF_REQ = 0`;
  - saturates at `MAX_DATA_STREAK`.
- Requester rules:
  - A requester holds REQ and its payload stable until its VALID.
  - Dropping REQ mid-transaction does not abort it: the transaction completes and VALID still pulses.
  - Payload changes after grant are ignored.
- Reset:
  - State IDLE, `cnt = 0`, `streak = 0`.
  - All outputs 0: `MEM_*`, `*_RDATA`, `*_VALID`. The `STALL_*` outputs follow their combinational equations.
  - Reset asserted mid-transaction aborts it with no VALID; the memory sees no further enable.

## Timing

- Request seen in IDLE in cycle t:
  - ISSUE at t+1;
  - WAIT from t+2 to t+1+`MEM_LATENCY`;
  - VALID at t+2+`MEM_LATENCY` (t+4 with default parameters).
- Back-to-back: the earliest next ISSUE is 2 cycles after DONE (DONE → IDLE → ISSUE). Per-access occupancy is `MEM_LATENCY + 3` cycles.
- `MEM_RDEN`/`MEM_WE` are high only in the ISSUE cycle and are never both high.
- VALID is never high for both requesters in the same cycle.
- `STALL_*` drops in the same cycle as the matching VALID.

## Structure

- Shared package `otter_mem_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, DONE};
  - `arb_owner_t` enum {OWN_IF, OWN_MA};
  - constant `MEM_SIZE_WORD = 3'b010`.
- Single module with no sub-module. The latency counter and streak counter are inline registers.

## Test plan

- Single IF read from 0x100, memory model returning 0xDEADBEEF, default parameters → `MEM_RDEN` high only at t+1, `IF_VALID` pulse at t+4 with `IF_RDATA = 0xDEADBEEF`, `STALL_IF` high t..t+3.
- MA store: addr 0x2000, wdata 0x12345678, size 3'b010 → `MEM_WE` pulse with those values, `MA_VALID` at t+4, `MA_RDATA = 0`, `MEM_RDEN` never high.
- IF and MA both held high continuously → grant order MA, MA, MA, MA, IF, MA…; IF is never starved more than 4 consecutive grants.
- `MEM_LATENCY = 1` and `MEM_LATENCY = 5` builds → VALID at t+3 and t+7 respectively, data correct.
- `ARB_RESET` asserted during WAIT → next cycle state IDLE, no VALID pulse, all outputs 0; a new request afterwards completes normally.
- MA drops `MA_REQ` during WAIT → transaction still completes with a `MA_VALID` pulse; a pending IF is granted in the following IDLE.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER main-memory port arbiter.
package otter_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  typedef enum logic {OWN_IF, OWN_MA} arb_owner_t;

  localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        we;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported OTTER main memory between instruction fetch (IF)
// and the memory-stage load/store path (MA), one transaction in flight.
module mem_port_arbiter
  import otter_mem_pkg::*;
#(
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        ARB_CLOCK,
  input  logic        ARB_RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_VALID,
  input  logic        MA_REQ,
  input  logic        MA_WE,
  input  logic [31:0] MA_ADDR,
  input  logic [31:0] MA_WDATA,
  input  logic [2:0]  MA_SIZE,
  output logic [31:0] MA_RDATA,
  output logic        MA_VALID,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [2:0]  MEM_SIZE,
  output logic        MEM_RDEN,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RDATA,
  output logic        STALL_IF,
  output logic        STALL_MA
);

  // state | meaning
  // IDLE  | nothing in flight; arbitrate and capture the winner's payload
  // ISSUE | memory enable high for exactly one cycle
  // WAIT  | latency down-counter runs; read data captured at terminal count
  // DONE  | owner's VALID pulses with the captured word

  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  mem_req_t            req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         ma_rdata_q, ma_rdata_d;
  logic                grant_if, grant_ma;
  logic                cnt_tc;

  assign cnt_tc = (cnt_q == '0);

  // MA wins ties until it has taken MAX_DATA_STREAK grants in a row past a waiting IF.
  always_comb begin
    grant_if = 1'b0;
    grant_ma = 1'b0;
    if (state_q == IDLE) begin
      if (IF_REQ && (!MA_REQ || (streak_q == STREAK_MAX))) begin
        grant_if = 1'b1;
      end else if (MA_REQ) begin
        grant_ma = 1'b1;
      end
    end
  end

  always_ff @(posedge ARB_CLOCK) begin
    if (ARB_RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_if || grant_ma) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MEM_RDEN = 1'b0;
    MEM_WE   = 1'b0;
    IF_VALID = 1'b0;
    MA_VALID = 1'b0;
    case (state_q)
      ISSUE: begin
        MEM_RDEN = ~req_q.we;
        MEM_WE   = req_q.we;
      end
      DONE: begin
        IF_VALID = (owner_q == OWN_IF);
        MA_VALID = (owner_q == OWN_MA);
      end
      default: ;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    ma_rdata_d = ma_rdata_q;

    if (grant_if) begin
      req_d    = '{addr: IF_ADDR, wdata: 32'h0, size: MEM_SIZE_WORD, we: 1'b0};
      owner_d  = OWN_IF;
      streak_d = '0;
    end else if (grant_ma) begin
      req_d   = '{addr: MA_ADDR, wdata: MA_WDATA, size: MA_SIZE, we: MA_WE};
      owner_d = OWN_MA;
      if (!IF_REQ) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end

    if (state_q == ISSUE) begin
      cnt_d = CNT_LOAD;
    end else if (state_q == WAIT) begin
      if (cnt_tc) begin
        // A store has no read data; its owner sees zero.
        if (owner_q == OWN_IF) begin
          if_rdata_d = req_q.we ? 32'h0 : MEM_RDATA;
        end else begin
          ma_rdata_d = req_q.we ? 32'h0 : MEM_RDATA;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ARB_CLOCK) begin
    if (ARB_RESET) begin
      req_q      <= '0;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      ma_rdata_q <= '0;
    end else begin
      req_q      <= req_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      ma_rdata_q <= ma_rdata_d;
    end
  end

  assign MEM_ADDR  = req_q.addr;
  assign MEM_WDATA = req_q.wdata;
  assign MEM_SIZE  = req_q.size;
  assign IF_RDATA  = if_rdata_q;
  assign MA_RDATA  = ma_rdata_q;
  assign STALL_IF  = IF_REQ & ~IF_VALID;
  assign STALL_MA  = MA_REQ & ~MA_VALID;

endmodule
